display_saida: RTL and testbench

Output-side peripheral fed by the CPU's 16-bit `saida` register. It shows the value as four hexadecimal digits on a multiplexed, common-anode 7-segment display. The value is captured only at frame boundaries, so no digit ever shows a torn value. The block has optional leading-zero blanking and a decimal-point "new value" indicator that stays lit for a programmable number of frames after the displayed value changes.

---
 rtl/display_pkg.sv | 16 +
 rtl/display_saida_hex_7seg.sv | 12 +
 rtl/display_saida.sv | 111 +++++++++++
 tb/tb_display_saida.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants for the display_saida 7-segment driver.
// Provides the hex font, the blank pattern and the all-off anode value.
package display_pkg;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
  localparam logic [6:0] SEG_FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

endpackage

// File: rtl/display_saida_hex_7seg.sv
// hex_7seg: combinational nibble to active-low 7-segment pattern.
// Ports: i_nib (4-bit digit value), o_seg (7-bit pattern {g..a}).
module hex_7seg
  import display_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_FONT[i_nib];

endmodule

// File: rtl/display_saida.sv
// display_saida: shows the 16-bit CPU value as four multiplexed hex digits.
// Ports: clk, rst (async high), dado, blank_zeros -> an, seg, dp (active-low).
module display_saida
  import display_pkg::*;
#(
  parameter int DIV_WIDTH  = 16,
  parameter int NEW_FRAMES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] dado,
  input  logic        blank_zeros,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam logic [7:0] NF = 8'(NEW_FRAMES);

  logic [DIV_WIDTH-1:0] r_div;
  logic [1:0]           r_idx;
  logic [15:0]          r_valor;
  logic [7:0]           r_novo_cnt;
  logic [3:0]           r_an;
  logic [6:0]           r_seg;
  logic                 r_dp;

  logic                 w_tick;
  logic                 w_frame;
  logic [3:0]           w_nib;
  logic                 w_lead;
  logic [6:0]           w_font;
  logic [6:0]           w_seg;

  assign w_tick  = &r_div;
  assign w_frame = w_tick && (r_idx == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
      r_idx <= 2'd0;
    end else begin
      r_div <= r_div + 1'b1;
      if (w_tick)
        r_idx <= r_idx + 2'd1;
    end
  end

  // Capture only at the frame boundary so a frame never mixes two values.
  // A fresh value reloads the indicator ahead of any pending decrement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valor    <= 16'h0000;
      r_novo_cnt <= 8'd0;
    end else if (w_frame) begin
      r_valor <= dado;
      if (dado != r_valor)
        r_novo_cnt <= NF;
      else if (r_novo_cnt != 8'd0)
        r_novo_cnt <= r_novo_cnt - 8'd1;
    end
  end

  // w_lead: this digit and every digit above it are zero.
  always_comb begin
    w_nib  = r_valor[3:0];
    w_lead = 1'b0;
    unique case (r_idx)
      2'd0: begin
        w_nib  = r_valor[3:0];
        w_lead = 1'b0;
      end
      2'd1: begin
        w_nib  = r_valor[7:4];
        w_lead = (r_valor[15:4] == 12'h000);
      end
      2'd2: begin
        w_nib  = r_valor[11:8];
        w_lead = (r_valor[15:8] == 8'h00);
      end
      2'd3: begin
        w_nib  = r_valor[15:12];
        w_lead = (r_valor[15:12] == 4'h0);
      end
    endcase
  end

  hex_7seg u_font (
    .i_nib (w_nib),
    .o_seg (w_font)
  );

  assign w_seg = (blank_zeros && w_lead) ? SEG_BLANK : w_font;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= ~(4'b0001 << r_idx);
      r_seg <= w_seg;
      r_dp  <= !((r_idx == 2'd0) && (r_novo_cnt != 8'd0));
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule

// File: tb/tb_display_saida.sv
// Testbench for display_saida with DIV_WIDTH=2, NEW_FRAMES=2.
// Cycle-level reference model plus directed literal expectations.
module tb_display_saida;

  localparam int DIG   = 4;
  localparam int FRAME = 16;
  localparam int NF    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] dado = 16'h0000;
  logic        blank_zeros = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int checks   = 0;
  int failures = 0;

  display_saida #(
    .DIV_WIDTH  (2),
    .NEW_FRAMES (NF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .dado        (dado),
    .blank_zeros (blank_zeros),
    .an          (an),
    .seg         (seg),
    .dp          (dp)
  );

  always #5 clk = ~clk;

  logic [6:0] font [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Model: n counts clock edges since reset release; the digit shown
  // after edge n is the one selected during the previous cycle.
  int          n  = 0;
  int          mc = 0;
  int          md;
  logic [15:0] mv = 16'h0000;
  logic [15:0] sh;
  logic [3:0]  e_an  = 4'hF;
  logic [6:0]  e_seg = 7'h7F;
  logic        e_dp  = 1'b1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n = 0; mc = 0; mv = 16'h0000;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      n++;
      md = ((n - 1) / DIG) % 4;
      e_an = ~(4'b0001 << md);
      sh = mv >> (4 * md);
      if (blank_zeros && md > 0 && sh == 16'h0000)
        e_seg = 7'h7F;
      else
        e_seg = font[sh[3:0]];
      e_dp = !(md == 0 && mc != 0);
      if (n % FRAME == 0) begin
        if (dado != mv) mc = NF;
        else if (mc != 0) mc--;
        mv = dado;
      end
    end
  end

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h (n=%0d)", nm, act, exp, n);
    end
  endtask

  always @(negedge clk)
    chk("model", {an, seg, dp}, {e_an, e_seg, e_dp});

  task automatic wait_n(int k);
    int g = 0;
    while (n < k && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (n != k) chk("wait_n", 16'(n), 16'(k));
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    wait_n(3);   dado = 16'h1A2F;
    wait_n(18);  chk("font_d0", 16'(seg), 16'h0E); chk("ind_f1", 16'(dp), 16'h0);
    wait_n(22);  chk("font_d1", 16'(seg), 16'h24);
    wait_n(26);  chk("font_d2", 16'(seg), 16'h08);
    wait_n(30);  chk("font_d3", 16'(seg), 16'h79);
    wait_n(34);  chk("ind_f2", 16'(dp), 16'h0);
    wait_n(50);  chk("ind_f3", 16'(dp), 16'h1);

    wait_n(60);  blank_zeros = 1'b1; dado = 16'h0005;
    wait_n(66);  chk("blk5_d0", 16'(seg), 16'h12);
    wait_n(70);  chk("blk5_d1", 16'(seg), 16'h7F);
    wait_n(78);  chk("blk5_d3", 16'(seg), 16'h7F);
    wait_n(79);  dado = 16'h0000;
    wait_n(82);  chk("blk0_d0", 16'(seg), 16'h40);
    wait_n(86);  chk("blk0_d1", 16'(seg), 16'h7F);
    wait_n(95);  dado = 16'h0100;
    wait_n(98);  chk("b100_d0", 16'(seg), 16'h40);
    wait_n(102); chk("b100_d1", 16'(seg), 16'h40);
    wait_n(106); chk("b100_d2", 16'(seg), 16'h79);
    wait_n(110); chk("b100_d3", 16'(seg), 16'h7F);

    wait_n(111); blank_zeros = 1'b0; dado = 16'h1111;
    wait_n(114); chk("tear_a", 16'(seg), 16'h79);
    wait_n(120); dado = 16'h2222;
    wait_n(122); chk("tear_b", 16'(seg), 16'h79);
    wait_n(126); chk("tear_c", 16'(seg), 16'h79);
    wait_n(130); chk("new_d0", 16'(seg), 16'h24); chk("ind_a", 16'(dp), 16'h0);
    wait_n(140); dado = 16'h3333;
    wait_n(142); chk("new_d3", 16'(seg), 16'h24);
    wait_n(146); chk("rld_f1", 16'(dp), 16'h0); chk("rld_seg", 16'(seg), 16'h30);
    wait_n(162); chk("rld_f2", 16'(dp), 16'h0);
    wait_n(178); chk("rld_f3", 16'(dp), 16'h1);
    wait_n(194); chk("hold_a", 16'(dp), 16'h1);
    wait_n(210); chk("hold_b", 16'(dp), 16'h1);
    wait_n(242); chk("hold_c", 16'(dp), 16'h1);

    wait_n(250);
    #2 rst = 1'b1;
    #1;
    chk("rst_an", 16'(an), 16'hF);
    chk("rst_seg", 16'(seg), 16'h7F);
    chk("rst_dp", 16'(dp), 16'h1);
    @(negedge clk);
    rst = 1'b0;
    wait_n(1);  chk("seq_E", 16'(an), 16'hE);
    wait_n(2);  chk("rst_val", 16'(seg), 16'h40); chk("rst_ind", 16'(dp), 16'h1);
    wait_n(5);  chk("seq_D", 16'(an), 16'hD);
    wait_n(9);  chk("seq_B", 16'(an), 16'hB);
    wait_n(13); chk("seq_7", 16'(an), 16'h7);
    wait_n(17); chk("seq_E2", 16'(an), 16'hE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
